clken_gen: RTL and testbench
============================

Name: clken_gen

Overview:
- Multi-channel fractional clock-enable generator, clocked from the single PLL system clock.
- Derives N independent enable strobes, e.g. CPU 1 MHz and pixel enables, from one fast clock using phase accumulators. This avoids a dedicated PLL output per rate.
- Gates all enables and the downstream reset on a filtered, synchronised PLL lock indication.
- Sits between the PLL wrapper and the core logic.

Parameters:
NUM_CH, 2, number of independent enable channels (1..8)
ACC_W, 24, phase accumulator width per channel (8..32)
LOCK_FILT, 1024, consecutive cycles of synchronised lock required before enables run (>=2)

Ports:
clk  input  1  system clock; the single clock of this block
rst_n  input  1  asynchronous, active-low reset
pll_locked  input  1  raw PLL lock, asynchronous to clk
ch_inc  input  NUM_CH*ACC_W  per-channel phase increment; channel k occupies bits [k*ACC_W +: ACC_W]
ch_run  input  NUM_CH  per-channel run enable
ce_out  output  NUM_CH  per-channel single-cycle enable strobe
ready  output  1  high in RUN state
core_rst  output  1  active-high reset for downstream logic; equals !ready, registered

Behaviour:
- Reset (rst_n low, asynchronous):
  - ce_out=0, ready=0, core_rst=1.
  - All accumulators=0, filter counter=0, synchroniser=0, state=WAIT_LOCK.
- Lock synchroniser: 2-flop, reset to 0. Call its output lk.
- State machine:
  - WAIT_LOCK: counter held at 0. When lk=1, go to SETTLE.
  - SETTLE: counter increments each cycle while lk=1. When counter reaches LOCK_FILT-1 with lk=1, go to RUN. If lk=0 at any point, go to WAIT_LOCK and clear the counter.
  - RUN: ready=1. If lk=0, go to WAIT_LOCK on the next edge.
- Filter counter width: clog2(LOCK_FILT). It must not wrap.
- ready/core_rst are registered from state:
  - ready rises on the first cycle state==RUN.
  - core_rst falls in the same cycle ready rises.
- Accumulator k:
  - While state==RUN and ch_run[k]=1: {carry, acc} = acc + inc_k, computed (ACC_W+1) wide. ce_out[k] is registered from carry, so ce_out lags the accumulate edge by 1 cycle.
  - Average rate = f_clk * inc_k / 2^ACC_W.
  - ce_out[k] is always a single-cycle pulse; it can be high on consecutive cycles only if inc_k >= 2^(ACC_W-1).
- ch_run[k]=0: acc_k holds its value and ce_out[k]=0 the next cycle. Re-asserting ch_run[k] resumes from the held phase.
- inc_k=0: acc_k never changes and no strobes are produced.
- ch_inc is sampled every cycle; a change takes effect on the next accumulate.
- Lock loss in RUN: on the cycle state leaves RUN:
  - all accumulators clear to 0;
  - ce_out=0 from the following cycle;
  - ready=0 and core_rst=1.
- No strobe is ever emitted outside RUN.
- Simultaneous lock loss and carry: lock loss wins, and the strobe is suppressed.
- rst_n asserted mid-operation: all outputs take their reset values immediately (asynchronous).

Optional Feature:
CLKEN_PHASE_SYNC_EN
- Defined:
  - Adds input port phase_sync (1 bit, synchronous to clk).
  - phase_sync=1 in RUN clears every accumulator to 0 that cycle and suppresses the carry.
  - Channels with related increments then restart phase-aligned, and their first strobes are coincident.
  - phase_sync has priority over ch_run hold.
  - phase_sync is ignored outside RUN.
- Undefined: the port is absent and accumulators clear only on reset or lock loss.

Test Plan:
1. Reset release with pll_locked held 0 for 5000 cycles -> ready=0, core_rst=1, ce_out=0 throughout.
2. Lock sequencing (LOCK_FILT=16):
   - Raise pll_locked; pulse it low 1 cycle after 10 cycles -> RUN is not entered.
   - Then hold it high -> ready rises exactly 2 (sync) + 1 + 16 + 1 cycles after the final rising edge of pll_locked. Bench checks this count.
3. Rates (ACC_W=24):
   - ch0 inc=0x400000 -> ce_out[0] every 4th cycle.
   - ch1 inc=0x800000 -> every 2nd cycle.
   - Over 1024 cycles, counts are 256 and 512 exactly.
   - inc=0xFFFFFF -> strobes on every cycle except the first after RUN.
4. Hold and zero:
   - ch0 inc=0x400000; deassert ch_run[0] after 3 accumulates for 10 cycles, then reassert -> next strobe after exactly 1 more accumulate.
   - inc=0 -> no strobes over 1000 cycles.
5. Lock loss in RUN:
   - Drop pll_locked -> ready falls and ce_out is all 0 within 4 cycles.
   - Accumulators read 0 on relock; first ch0 strobe (inc=0x400000) comes 4 cycles after ready.
6. (CLKEN_PHASE_SYNC_EN) ch0 inc=0x400000, ch1 inc=0x200000, misaligned by ch_run staggering; pulse phase_sync -> ch0 strobes 4 cycles and ch1 strobes 8 cycles after the pulse, coinciding every 8 cycles.

Source files
------------

// File: rtl/clken_gen.sv
// rtl/clken_gen.sv - multi-channel fractional clock-enable generator with PLL lock gating
// Optional feature macro: CLKEN_PHASE_SYNC_EN (adds phase_sync input to realign all accumulators)
module clken_gen #(
   parameter int NUM_CH    = 2,
   parameter int ACC_W     = 24,
   parameter int LOCK_FILT = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    pll_locked,
   input  logic [NUM_CH*ACC_W-1:0] ch_inc,
   input  logic [NUM_CH-1:0]       ch_run,
`ifdef CLKEN_PHASE_SYNC_EN
   input  logic                    phase_sync,
`endif
   output logic [NUM_CH-1:0]       ce_out,
   output logic                    ready,
   output logic                    core_rst
);

   localparam int CNT_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_FILT - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             lk_meta;
   logic             lk;
   logic             acc_en;
   logic             psync;

   // two-flop synchroniser for the asynchronous PLL lock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lk_meta <= 1'b0;
         lk      <= 1'b0;
      end else begin
         lk_meta <= pll_locked;
         lk      <= lk_meta;
      end
   end

   // lock filter state machine; ready/core_rst follow the state one edge later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= WAIT_LOCK;
         cnt      <= '0;
         ready    <= 1'b0;
         core_rst <= 1'b1;
      end else begin
         ready    <= (state == RUN);
         core_rst <= (state != RUN);
         case (state)
            WAIT_LOCK: begin
               cnt <= '0;
               if (lk) state <= SETTLE;
            end
            SETTLE: begin
               if (!lk) begin
                  state <= WAIT_LOCK;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= RUN;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RUN: begin
               cnt <= '0;
               if (!lk) state <= WAIT_LOCK;
            end
            default: begin
               state <= WAIT_LOCK;
               cnt   <= '0;
            end
         endcase
      end
   end

   // accumulators only advance while RUN is visible on ready and lock is still
   // present, so a lock drop clears them on the same edge the state leaves RUN
   assign acc_en = (state == RUN) && ready && lk;

`ifdef CLKEN_PHASE_SYNC_EN
   assign psync = phase_sync;
`else
   assign psync = 1'b0;
`endif

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [ACC_W-1:0] acc;
      logic [ACC_W:0]   sum;
      logic             ce_q;

      assign sum       = {1'b0, acc} + {1'b0, ch_inc[k*ACC_W +: ACC_W]};
      assign ce_out[k] = ce_q;

      // phase accumulator; the carry out becomes the registered strobe
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            acc  <= '0;
            ce_q <= 1'b0;
         end else if (!acc_en || psync) begin
            acc  <= '0;
            ce_q <= 1'b0;
         end else if (ch_run[k]) begin
            acc  <= sum[ACC_W-1:0];
            ce_q <= sum[ACC_W];
         end else begin
            ce_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clken_gen.sv
// tb/tb_clken_gen.sv - directed self-checking bench for clken_gen
module tb_clken_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pll_locked;
   logic [47:0] ch_inc;
   logic [1:0]  ch_run;
   logic        phase_sync;
   logic [1:0]  ce_out;
   logic        ready;
   logic        core_rst;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   clken_gen #(.NUM_CH(2), .ACC_W(24), .LOCK_FILT(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .ch_inc     (ch_inc),
      .ch_run     (ch_run),
`ifdef CLKEN_PHASE_SYNC_EN
      .phase_sync (phase_sync),
`endif
      .ce_out     (ce_out),
      .ready      (ready),
      .core_rst   (core_rst)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_lock();
      pll_locked = 1'b0;
      repeat (6) tick();
   endtask

   task automatic relock(output int n);
      pll_locked = 1'b1;
      n = 0;
      while (!ready && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL relock_timeout ready=%b required=1", ready);
      end
   endtask

   task automatic test_reset();
      int bad;
      rst_n = 1'b0; pll_locked = 1'b0; ch_inc = '0; ch_run = '0; phase_sync = 1'b0;
      repeat (3) tick();
      checks++;
      if (ready !== 1'b0 || core_rst !== 1'b1 || ce_out !== 2'b00) begin
         failures++;
         $display("FAIL reset_state ready=%b core_rst=%b ce=%b required 0/1/00", ready, core_rst, ce_out);
      end
      ch_inc = {24'h800000, 24'h400000}; ch_run = 2'b11;
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 5000; i++) begin
         tick();
         if (ready !== 1'b0 || core_rst !== 1'b1 || ce_out !== 2'b00) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL no_lock_idle bad_cycles=%0d required=0", bad);
      end
      ch_inc = '0; ch_run = '0;
   endtask

   task automatic test_lock_seq();
      int bad;
      int n;
      bad = 0;
      pll_locked = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ready !== 1'b0) bad++;
      end
      pll_locked = 1'b0;
      tick();
      if (ready !== 1'b0) bad++;
      pll_locked = 1'b1;
      n = 0;
      while (ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL glitch_no_run bad_cycles=%0d required=0", bad);
      end
      checks++;
      if (n != 20) begin
         failures++;
         $display("FAIL lock_latency cycles=%0d required=20", n);
      end
      checks++;
      if (core_rst !== 1'b0) begin
         failures++;
         $display("FAIL core_rst_release core_rst=%b required=0", core_rst);
      end
   endtask

   task automatic test_rates();
      int c0, c1, last0, last1, bad0, bad1;
      ch_inc = {24'h800000, 24'h400000}; ch_run = 2'b11;
      repeat (8) tick();
      c0 = 0; c1 = 0; last0 = -1; last1 = -1; bad0 = 0; bad1 = 0;
      for (int i = 0; i < 1024; i++) begin
         tick();
         if (ce_out[0]) begin
            c0++;
            if (last0 >= 0 && i - last0 != 4) bad0++;
            last0 = i;
         end
         if (ce_out[1]) begin
            c1++;
            if (last1 >= 0 && i - last1 != 2) bad1++;
            last1 = i;
         end
      end
      checks++;
      if (c0 != 256) begin failures++; $display("FAIL rate_ch0_count got=%0d required=256", c0); end
      checks++;
      if (c1 != 512) begin failures++; $display("FAIL rate_ch1_count got=%0d required=512", c1); end
      checks++;
      if (bad0 != 0) begin failures++; $display("FAIL rate_ch0_spacing bad=%0d required=0", bad0); end
      checks++;
      if (bad1 != 0) begin failures++; $display("FAIL rate_ch1_spacing bad=%0d required=0", bad1); end
   endtask

   task automatic test_full_rate();
      int n, bad;
      drop_lock();
      ch_inc = {24'h000000, 24'hFFFFFF}; ch_run = 2'b11;
      relock(n);
      checks++;
      if (n != 20) begin failures++; $display("FAIL relock_latency cycles=%0d required=20", n); end
      tick();
      checks++;
      if (ce_out !== 2'b00) begin
         failures++;
         $display("FAIL full_rate_first ce=%b required=00", ce_out);
      end
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ce_out !== 2'b01) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL full_rate_every_cycle bad=%0d required=0", bad); end
   endtask

   task automatic test_hold_zero();
      int n, bad, cnt;
      drop_lock();
      ch_inc = {24'h000000, 24'h400000}; ch_run = 2'b01;
      relock(n);
      bad = 0;
      repeat (3) begin
         tick();
         if (ce_out !== 2'b00) bad++;
      end
      ch_run = 2'b00;
      repeat (10) begin
         tick();
         if (ce_out !== 2'b00) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL hold_quiet bad=%0d required=0", bad); end
      ch_run = 2'b01;
      tick();
      checks++;
      if (ce_out !== 2'b01) begin failures++; $display("FAIL hold_resume ce=%b required=01", ce_out); end
      tick();
      checks++;
      if (ce_out !== 2'b00) begin failures++; $display("FAIL hold_single_pulse ce=%b required=00", ce_out); end
      ch_inc = '0; ch_run = 2'b11;
      cnt = 0;
      repeat (1000) begin
         tick();
         if (ce_out !== 2'b00) cnt++;
      end
      checks++;
      if (cnt != 0) begin failures++; $display("FAIL zero_inc strobes=%0d required=0", cnt); end
   endtask

   task automatic test_lock_loss();
      int n, bad;
      logic [1:0] exp_ce;
      ch_inc = {24'h800000, 24'h400000}; ch_run = 2'b11;
      repeat (5) tick();
      pll_locked = 1'b0;
      repeat (4) tick();
      checks++;
      if (ready !== 1'b0 || core_rst !== 1'b1 || ce_out !== 2'b00) begin
         failures++;
         $display("FAIL lock_loss ready=%b core_rst=%b ce=%b required 0/1/00", ready, core_rst, ce_out);
      end
      bad = 0;
      repeat (20) begin
         tick();
         if (ce_out !== 2'b00) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL no_strobe_outside_run bad=%0d required=0", bad); end
      relock(n);
      bad = 0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         exp_ce = {(k == 2 || k == 4), (k == 4)};
         if (ce_out !== exp_ce) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL relock_phase bad=%0d required=0", bad); end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b0 || core_rst !== 1'b1 || ce_out !== 2'b00) begin
         failures++;
         $display("FAIL async_reset ready=%b core_rst=%b ce=%b required 0/1/00", ready, core_rst, ce_out);
      end
      tick();
      rst_n = 1'b1;
      pll_locked = 1'b0;
      tick();
   endtask

`ifdef CLKEN_PHASE_SYNC_EN
   task automatic test_phase_sync();
      int n, bad;
      logic [1:0] exp_ce;
      ch_inc = {24'h200000, 24'h400000}; ch_run = 2'b01;
      relock(n);
      repeat (3) tick();
      ch_run = 2'b11;
      repeat (5) tick();
      phase_sync = 1'b1;
      tick();
      phase_sync = 1'b0;
      checks++;
      if (ce_out !== 2'b00) begin failures++; $display("FAIL phase_sync_clear ce=%b required=00", ce_out); end
      bad = 0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp_ce = {(k % 8 == 0), (k % 4 == 0)};
         if (ce_out !== exp_ce) bad++;
      end
      checks++;
      if (bad != 0) begin failures++; $display("FAIL phase_sync_align bad=%0d required=0", bad); end
   endtask
`endif

   initial begin
      test_reset();
      test_lock_seq();
      test_rates();
      test_full_rate();
      test_hold_zero();
      test_lock_loss();
      test_async_reset();
`ifdef CLKEN_PHASE_SYNC_EN
      test_phase_sync();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
